// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
package mux_arb_pkg;

  // Controller state: IDLE means no grant outstanding, GRANT means one owner.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Default configuration of the block.
  localparam int N_DEF        = 4;
  localparam int W_DEF        = 8;
  localparam int MAX_HOLD_DEF = 4;

  // Widest requester vector the onehot helper can produce.
  localparam int MAX_N = 32;

  // Select width for n requesters; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Hold counter width: must be able to hold values up to max_hold.
  function automatic int hold_width(input int max_hold);
    return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
  endfunction

  // One-hot vector with bit idx set; callers truncate to N bits.
  function automatic logic [MAX_N-1:0] onehot(input int unsigned idx);
    return MAX_N'(1) << idx;
  endfunction

endpackage

// File: rtl/mux_arbiter_rr_pick.sv
// Wrap-around priority scan: first set bit of (req & mask) starting at ptr.
module rr_pick
  import mux_arb_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int SW = sel_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  input  logic [N-1:0]  mask,
  output logic          found,
  output logic [SW-1:0] idx
);

  logic [N-1:0] cand;
  int           pos;

  // Scan ptr, ptr+1, ... N-1, 0, ... ptr-1 and keep the first candidate.
  always_comb begin
    cand  = req & mask;
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      if (!found && cand[pos]) begin
        found = 1'b1;
        idx   = SW'(pos);
      end
    end
  end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin controller for an N-input, W-bit mux: one owner at a time,
// tenure capped at MAX_HOLD cycles under contention, registered output word.
//
// Handshake: req[i] is a level request, held high while requester i wants
// the mux; gnt[i] high means requester i owns the mux this cycle and its
// data is sampled at the next edge. out_valid qualifies out one cycle later.
// There is no backpressure on out.
//
// state, ptr and hold_cnt are exported purely for observation.
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int  N        = N_DEF,
  parameter int  W        = W_DEF,
  parameter int  MAX_HOLD = MAX_HOLD_DEF,
  localparam int SW       = sel_width(N),
  localparam int HW       = hold_width(MAX_HOLD)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] in,
  output logic [N-1:0]   gnt,
  output logic [SW-1:0]  sel,
  output logic           ena,
  output logic [W-1:0]   out,
  output logic           out_valid,
  output logic           state,
  output logic [SW-1:0]  ptr,
  output logic [HW-1:0]  hold_cnt
);

  localparam logic [SW-1:0] LAST = SW'(N - 1);
  localparam logic [HW-1:0] CAP  = HW'(MAX_HOLD - 1);

  state_t        st;
  logic [SW-1:0] ptr_q;
  logic [HW-1:0] hold_q;

  logic [N-1:0]  oh_sel;
  logic [SW-1:0] nxt_sel;
  logic          at_cap;
  logic          others;
  logic          rel;
  logic [SW-1:0] pick_ptr;
  logic [N-1:0]  pick_mask;
  logic          pick_found;
  logic [SW-1:0] pick_idx;

  // Release decision and scan setup. In GRANT the scan always starts after
  // the current owner with the owner masked out, so its result is directly
  // the hand-off target whenever a release happens.
  always_comb begin
    oh_sel  = N'(onehot(32'(sel)));
    nxt_sel = (sel == LAST) ? '0 : sel + 1'b1;
    at_cap  = (hold_q == CAP);
    others  = |(req & ~oh_sel);
    rel     = !req[sel] || (at_cap && others);
    if (st == GRANT) begin
      pick_ptr  = nxt_sel;
      pick_mask = ~oh_sel;
    end else begin
      pick_ptr  = ptr_q;
      pick_mask = '1;
    end
  end

  rr_pick #(
    .N  (N),
    .SW (SW)
  ) u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .mask  (pick_mask),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Grant FSM: owns gnt/sel/ena, the round-robin pointer and tenure counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= IDLE;
      gnt    <= '0;
      sel    <= '0;
      ena    <= 1'b0;
      ptr_q  <= '0;
      hold_q <= '0;
    end else begin
      case (st)
        IDLE: begin
          if (pick_found) begin
            st     <= GRANT;
            gnt    <= N'(onehot(32'(pick_idx)));
            sel    <= pick_idx;
            ena    <= 1'b1;
            hold_q <= '0;
          end
        end
        GRANT: begin
          if (rel) begin
            ptr_q  <= nxt_sel;
            hold_q <= '0;
            if (pick_found) begin
              // Direct hand-off, no idle bubble between tenures.
              gnt <= N'(onehot(32'(pick_idx)));
              sel <= pick_idx;
            end else begin
              st  <= IDLE;
              gnt <= '0;
              sel <= '0;
              ena <= 1'b0;
            end
          end else begin
            // A lone owner at the cap keeps the mux; the counter wraps.
            hold_q <= at_cap ? '0 : hold_q + HW'(1);
          end
        end
        default: begin
          st     <= IDLE;
          gnt    <= '0;
          sel    <= '0;
          ena    <= 1'b0;
          hold_q <= '0;
        end
      endcase
    end
  end

  // Output register: capture the selected word while the mux is enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else if (ena) begin
      out       <= in[sel*W +: W];
      out_valid <= 1'b1;
    end else begin
      out       <= '0;
      out_valid <= 1'b0;
    end
  end

  assign state    = st;
  assign ptr      = ptr_q;
  assign hold_cnt = hold_q;

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Round-robin controller that shares one N-input, W-bit datapath multiplexer among N requesters. It grants the mux to one requester at a time and drives the select and enable lines. It caps each tenure at MAX_HOLD cycles when others are waiting, and registers the selected data onto a single output with a valid flag. It sits directly in front of the mux2/mux4 family as the block that sequences their `ena`/select inputs.

## Interface
- N, 4, number of requesters (≥2)
- W, 8, data width per requester
- MAX_HOLD, 4, maximum consecutive grant cycles while another requester waits (≥1)
- SW, $clog2(N), select width (localparam)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req  in  N  per-requester request, level; held high while the requester wants the mux
- in  in  N×W  packed data, requester i at in[i*W +: W]
- gnt  out  N  one-hot grant, registered; all-zero when idle
- sel  out  SW  index of current grantee, registered; 0 when idle
- ena  out  1  mux enable, registered; equals |gnt
- out  out  W  registered mux output
- out_valid  out  1  high when out holds data captured under a grant

## Operation
- Reset values: gnt=0, sel=0, ena=0, out=0, out_valid=0, state=IDLE, ptr=0, hold_cnt=0.
- ptr is the round-robin start index. The winner is the first i with req[i]=1, scanning ptr, ptr+1, …, N−1, 0, …, ptr−1 (mod N).
- IDLE:
  - If req≠0, the next edge sets gnt/sel to the winner, sets ena=1, sets hold_cnt=0, and moves to GRANT.
  - Otherwise stay in IDLE.
- GRANT, current grantee c:
  - Release when req[c]=0, or when hold_cnt=MAX_HOLD−1 and (req & ~onehot(c))≠0.
  - On release, ptr←(c+1) mod N and the winner is recomputed from the new ptr with req[c] masked off.
  - If a winner exists, the grant moves to it on the same edge, with no idle bubble, and hold_cnt←0.
  - If no winner exists, go to IDLE.
  - Otherwise hold the grant and hold_cnt←hold_cnt+1.
  - If c is the only requester at the cap, it keeps the grant and hold_cnt wraps to 0.
- Output register:
  - When ena=1: out←in[sel], out_valid←1.
  - When ena=0: out←0, out_valid←0.
- Arithmetic: ptr and sel wrap mod N (non-power-of-2 N supported). hold_cnt is $clog2(MAX_HOLD+1) bits and never exceeds MAX_HOLD−1.
- Grant is always one-hot or zero. It is never granted to a requester whose req was low at the deciding edge.
- Reset mid-tenure clears all state immediately (async). The first grant after reset follows ptr=0.

## Timing
- Latency:
  - req[i] rises before edge k → gnt[i]/ena high after edge k.
  - out=in[i] (sampled at edge k+1) with out_valid high after edge k+1.
- Release:
  - req[c] falls before edge k → gnt[c] low after edge k.
  - The next grantee is high after the same edge.
  - out_valid drops one edge later only if the block went IDLE.
- Tenure: with contention, a requester holds the mux exactly MAX_HOLD cycles, unless it drops req earlier.
- Throughput: one W-bit word per cycle while any requester is granted.
- in is sampled only at edges when ena=1. Requesters must hold data stable for the cycle they are granted.

## Structure
- Package mux_arb_pkg:
  - state_t enum {IDLE, GRANT}
  - function onehot(idx) returning N bits
  - the SW computation
- Sub-module rr_pick (combinational):
  - inputs req[N], ptr[SW], mask[N]
  - outputs found, idx[SW]
  - implements the wrap-around priority scan
  - instantiated once; the top holds the FSM, counter and output register

## Test plan
- Single requester (N=4, W=8): req=0100, in[2]=8'hA5 → gnt=0100, sel=2 after 1 edge; out=8'hA5, out_valid=1 after 2 edges; drop req → gnt=0 next edge, out_valid=0 the edge after.
- Contention, MAX_HOLD=4: req=1111 held → grants 0,1,2,3,0 each for exactly 4 cycles, with no idle cycle between tenures.
- Early release: req=0011, grantee 0 drops req after 2 cycles → gnt=0010 on that edge; ptr then favours 2.
- Lone hog: only req[3] high for 10 cycles → gnt=1000 continuously, ena never drops, hold_cnt wraps.
- Wrap and mask: ptr=3 (last grant was 2), req=0101 → winner 0, not 2.
- Async reset mid-GRANT: assert rst_n=0 between edges → gnt, ena, out, out_valid zero immediately; after release with req=0110 → grant 1.
